// File: rtl/lc3_ctrl_pkg.sv
// Shared opcode constants, memory-FSM state encoding and opcode-class helpers
// for the LC3 pipeline controller.
package lc3_ctrl_pkg;

    localparam logic [3:0] OP_BR  = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_LD  = 4'd2;
    localparam logic [3:0] OP_ST  = 4'd3;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_LDR = 4'd6;
    localparam logic [3:0] OP_STR = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd9;
    localparam logic [3:0] OP_LDI = 4'd10;
    localparam logic [3:0] OP_STI = 4'd11;
    localparam logic [3:0] OP_JMP = 4'd12;
    localparam logic [3:0] OP_LEA = 4'd14;

    typedef enum logic [1:0] {
        MemRd   = 2'd0,
        MemInd  = 2'd1,
        MemWr   = 2'd2,
        MemIdle = 2'd3
    } mem_state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

    function automatic logic is_ctrl(input logic [3:0] op);
        return (op == OP_BR) || (op == OP_JMP);
    endfunction

    function automatic logic is_alu(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) || (op == OP_LEA);
    endfunction

    function automatic logic is_indirect(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

endpackage

// File: rtl/lc3_mem_fsm.sv
// Data-memory access sequencer: IDLE -> (IND ->) RD/WR -> IDLE, with a per-state
// wait counter that forces IDLE and raises a sticky timeout flag.
module lc3_mem_fsm
    import lc3_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [3:0] start_op_i,
    input  logic       complete_data_i,
    output mem_state_t mem_state_o,
    output logic       mem_busy_o,
    output logic       load_done_o,
    output logic       mem_timeout_o
);

    // Counter only needs to reach MEM_WAIT_MAX-1 before the timeout fires.
    localparam int unsigned CntW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

    mem_state_t      state_q, state_d;
    logic            is_load_q, is_load_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            load_done_q, load_done_d;
    logic            timeout_q, timeout_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= MemIdle;
            is_load_q   <= 1'b0;
            wait_cnt_q  <= '0;
            load_done_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_load_q   <= is_load_d;
            wait_cnt_q  <= wait_cnt_d;
            load_done_q <= load_done_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        is_load_d   = is_load_q;
        wait_cnt_d  = wait_cnt_q;
        load_done_d = 1'b0;
        timeout_d   = timeout_q;

        unique case (state_q)
            MemIdle: begin
                wait_cnt_d = '0;
                if (start_i) begin
                    is_load_d = is_load(start_op_i);
                    if (is_indirect(start_op_i)) begin
                        state_d = MemInd;
                    end else if (is_load(start_op_i)) begin
                        state_d = MemRd;
                    end else begin
                        state_d = MemWr;
                    end
                end
            end
            MemInd: begin
                if (complete_data_i) begin
                    state_d    = is_load_q ? MemRd : MemWr;
                    wait_cnt_d = '0;
                end
            end
            MemRd, MemWr: begin
                if (complete_data_i) begin
                    state_d     = MemIdle;
                    load_done_d = (state_q == MemRd);
                    wait_cnt_d  = '0;
                end
            end
        endcase

        if ((state_q != MemIdle) && !complete_data_i) begin
            if (wait_cnt_q == CntW'(MEM_WAIT_MAX - 1)) begin
                state_d    = MemIdle;
                timeout_d  = 1'b1;
                wait_cnt_d = '0;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
    end

    assign mem_state_o   = state_q;
    assign mem_busy_o    = (state_q != MemIdle);
    assign load_done_o   = load_done_q;
    assign mem_timeout_o = timeout_q;

endmodule

// File: rtl/lc3_pipe_controller.sv
// LC3 five-stage pipeline sequencer: stage enables, control-hazard bubbles, memory stalls.
// Optional ALU forwarding hints are built when LC3_CTRL_BYPASS_EN is defined.
module lc3_pipe_controller
    import lc3_ctrl_pkg::*;
#(
    parameter int unsigned BR_BUBBLES   = 3,
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] IR,
    input  logic [15:0] IR_Exec,
    input  logic [2:0]  NZP,
    input  logic [2:0]  psr,
    output logic        enable_fetch,
    output logic        enable_updatePC,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        br_taken,
    output logic [1:0]  mem_state,
    output logic        mem_timeout
`ifdef LC3_CTRL_BYPASS_EN
    ,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2
`endif
);

    localparam int unsigned BcW = $clog2(BR_BUBBLES + 1);

    logic           v_dec_q, v_dec_d;
    logic           v_exe_q, v_exe_d;
    logic           v_wb_q, v_wb_d;
    logic [BcW-1:0] bub_cnt_q, bub_cnt_d;

    logic [3:0] dec_op, exe_op;
    logic       mem_busy, load_done, hold_all, bubble;
    logic       dec_go, dec_ctrl, exe_go, exe_ctrl, mem_start;
    mem_state_t mem_state_w;

    assign dec_op = IR[15:12];
    assign exe_op = IR_Exec[15:12];

    // A finished load still owns the pipe for its writeback cycle.
    assign hold_all  = mem_busy | load_done;
    assign bubble    = (bub_cnt_q != '0);
    assign dec_go    = v_dec_q & ~hold_all & complete_instr;
    assign dec_ctrl  = dec_go & is_ctrl(dec_op);
    assign exe_go    = v_exe_q & ~hold_all;
    assign exe_ctrl  = exe_go & is_ctrl(exe_op);
    assign mem_start = exe_go & (is_load(exe_op) | is_store(exe_op));

    lc3_mem_fsm #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_mem_fsm (
        .clk_i           (clock),
        .rst_i           (reset),
        .start_i         (mem_start),
        .start_op_i      (exe_op),
        .complete_data_i (complete_data),
        .mem_state_o     (mem_state_w),
        .mem_busy_o      (mem_busy),
        .load_done_o     (load_done),
        .mem_timeout_o   (mem_timeout)
    );

    assign mem_state = mem_state_w;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v_dec_q   <= 1'b0;
            v_exe_q   <= 1'b0;
            v_wb_q    <= 1'b0;
            bub_cnt_q <= '0;
        end else begin
            v_dec_q   <= v_dec_d;
            v_exe_q   <= v_exe_d;
            v_wb_q    <= v_wb_d;
            bub_cnt_q <= bub_cnt_d;
        end
    end

    always_comb begin
        v_dec_d   = v_dec_q;
        v_exe_d   = v_exe_q;
        v_wb_d    = v_wb_q;
        bub_cnt_d = bub_cnt_q;
        if (!hold_all) begin
            if (dec_ctrl) begin
                bub_cnt_d = BcW'(BR_BUBBLES);
            end else if (bubble) begin
                bub_cnt_d = bub_cnt_q - 1'b1;
            end
            // Wrong-path fetches behind a control instruction never become valid.
            if (dec_ctrl || bubble) begin
                v_dec_d = 1'b0;
            end else if (complete_instr) begin
                v_dec_d = 1'b1;
            end
            v_exe_d = v_dec_q & complete_instr;
            // Memory ops retire through the FSM, so they leave no writeback slot here.
            v_wb_d  = v_exe_q & ~(is_load(exe_op) | is_store(exe_op));
        end
    end

    always_comb begin
        enable_fetch     = ~hold_all & ~bubble;
        enable_updatePC  = ~hold_all & ((~bubble & complete_instr) | exe_ctrl);
        enable_decode    = dec_go;
        enable_execute   = exe_go;
        enable_writeback = (v_wb_q & ~hold_all) | load_done;
        br_taken         = exe_ctrl &
                           ((exe_op == OP_JMP) || ((exe_op == OP_BR) && |(NZP & psr)));
    end

`ifdef LC3_CTRL_BYPASS_EN
    logic byp1_q, byp1_d;
    logic byp2_q, byp2_d;
    logic byp_base;
    logic src2_is_imm;

    assign byp_base    = v_exe_q & v_dec_q & is_alu(exe_op);
    assign src2_is_imm = ((dec_op == OP_ADD) || (dec_op == OP_AND)) & IR[5];

    always_comb begin
        byp1_d = byp1_q;
        byp2_d = byp2_q;
        if (!hold_all) begin
            byp1_d = byp_base & (IR[8:6] == IR_Exec[11:9]);
            byp2_d = byp_base & (IR[2:0] == IR_Exec[11:9]) & ~src2_is_imm;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byp1_q <= 1'b0;
            byp2_q <= 1'b0;
        end else begin
            byp1_q <= byp1_d;
            byp2_q <= byp2_d;
        end
    end

    assign bypass_alu_1 = byp1_q;
    assign bypass_alu_2 = byp2_q;
`endif

    // Operand fields not consumed by this controller are sunk here.
    logic unused_fields;
    assign unused_fields = ^{IR[11:0], IR_Exec[11:0]};

endmodule
